// File: rtl/cic_interp_modulator.sv
// cic_interp_modulator: rate-R handshaked sample input, N-stage CIC interpolator,
// gain normalisation and carrier multiply for the DAC path.
module cic_interp_modulator #(
    parameter int W = 12,
    parameter int R = 400,
    parameter int M = 1,
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    input  logic signed [W-1:0] carrier,
    input  logic                mod_en,
    input  logic                clr_underrun,
    output logic                tick,
    output logic signed [W-1:0] bb_out,
    output logic signed [W-1:0] mod_out,
    output logic                underrun
);
    function automatic longint gain_f();
        longint g = 1;
        for (int i = 0; i < N; i++) g = g * longint'(R * M);
        return g / R;
    endfunction

    localparam longint GAIN = gain_f();
    localparam int DW = W + $clog2(GAIN);
    localparam int CW = $clog2(R);
    localparam longint ATTN = ((longint'(1) << (DW - 1)) + GAIN / 2) / GAIN;
    // one spare bit so attn = 1.0 (unity CIC gain) still fits as a positive value
    localparam logic signed [DW:0] ATTN_V = (DW + 1)'(ATTN);
    localparam logic signed [2*DW:0] MAXV = (2 * DW + 1)'((1 << (W - 1)) - 1);
    localparam logic signed [2*DW:0] MINV = ~MAXV;

    logic [CW-1:0] cnt;
    logic full, tick_d, accept;
    logic signed [W-1:0] hold, bb_next, mod_next;
    logic signed [DW-1:0] dly [N][M];
    logic signed [DW-1:0] c [N+1];
    logic signed [DW-1:0] comb_out;
    logic signed [DW-1:0] integ [N];
    logic signed [2*DW:0] prod, scaled;
    logic signed [2*W-1:0] mprod;

    assign tick = cnt == CW'(R - 1);
    assign in_ready = ~full | tick;
    assign accept = in_valid & in_ready;

    always_comb begin
        c[0] = full ? DW'(hold) : '0;
        for (int k = 0; k < N; k++) c[k+1] = c[k] - dly[k][M-1];
    end

    assign prod = (2 * DW + 1)'(integ[N-1]) * (2 * DW + 1)'(ATTN_V);
    assign scaled = prod >>> (DW - 1);
    // attn rounding can overshoot full scale by one LSB; clip instead of wrapping
    assign bb_next = scaled > MAXV ? W'(MAXV) : scaled < MINV ? W'(MINV) : W'(scaled);
    assign mprod = (2 * W)'(bb_out) * (2 * W)'(carrier);
    assign mod_next = mod_en ? W'(mprod >>> (W - 1)) : bb_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            full <= 1'b0;
            hold <= '0;
            tick_d <= 1'b0;
            underrun <= 1'b0;
            comb_out <= '0;
            bb_out <= '0;
            mod_out <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
                for (int m = 0; m < M; m++) dly[k][m] <= '0;
            end
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            tick_d <= tick;
            if (accept) hold <= in_data;
            full <= accept | (full & ~tick);
            underrun <= (tick & ~full) | (underrun & ~clr_underrun);
            if (tick) begin
                comb_out <= c[N];
                for (int k = 0; k < N; k++) begin
                    dly[k][0] <= c[k];
                    for (int m = 1; m < M; m++) dly[k][m] <= dly[k][m-1];
                end
            end
            // zero-stuffing: the comb result enters the integrators for exactly one clock
            integ[0] <= integ[0] + (tick_d ? comb_out : '0);
            for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
            bb_out <= bb_next;
            mod_out <= mod_next;
        end
    end
endmodule
